adc_baseline_capture: RTL and testbench



---
 rtl/droopcor_pkg.sv | 28 ++
 rtl/capture_ram.sv | 25 ++
 rtl/adc_baseline_capture.sv | 110 +++++++++++
 tb/tb_adc_baseline_capture.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/droopcor_pkg.sv
// Shared constants, types and helpers for the droop-correction baseline path.
package droopcor_pkg;

  localparam int DATA_W = 14;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int SUM_W  = DATA_W + ADDR_W;

  typedef logic [DATA_W-1:0] adc_word_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [SUM_W-1:0]  sum_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

  // Rounded mean of a full window: add half an LSB of the divisor, then
  // shift. 512 * 16383 + 256 still fits SUM_W, so no extra bit is needed.
  function automatic adc_word_t round_mean(input sum_t total);
    sum_t rounded;
    rounded = total + sum_t'(DEPTH / 2);
    return adc_word_t'(rounded >> ADDR_W);
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Capture buffer: synchronous write, asynchronous (ROM-style) read.
module capture_ram
  import droopcor_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wraddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] rdaddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Store one sample per enabled clock edge.
  // NOTE: the array has no reset branch on purpose; clearing it would force
  // a flop-based implementation instead of a RAM.
  always_ff @(posedge clk) begin
    if (we) mem_q[wraddr] <= wdata;
  end

  // Zero-latency read; a same-cycle write to rdaddr shows up after the edge.
  assign rdata = mem_q[rdaddr];

endmodule

// File: rtl/adc_baseline_capture.sv
// Captures a 512-sample window of live ADC data into a ROM-compatible
// buffer and reports the rounded mean of the window as a baseline.
module adc_baseline_capture
  import droopcor_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig,
  input  logic [DATA_W-1:0] adc_in,
  input  logic              adc_valid,
  input  logic [ADDR_W-1:0] rdaddr,
  output logic [DATA_W-1:0] adc_val,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] baseline,
  output logic              baseline_valid
);

  cap_state_t state_q;
  addr_t      wr_ptr_q;
  sum_t       sum_q;
  adc_word_t  baseline_q;
  logic       baseline_valid_q;

  logic       wr_en;
  logic       last_write;
  sum_t       sum_d;

  // Decide whether this cycle's sample lands in the buffer. abort and arm
  // take priority, so a sample coincident with either is dropped.
  // NOTE: wr_en gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_en = 1'b0;
    if (!abort && !arm && adc_valid) begin
      case (state_q)
        ARMED:   wr_en = trig;
        CAPTURE: wr_en = 1'b1;
        default: wr_en = 1'b0;
      endcase
    end
  end

  assign sum_d      = sum_q + sum_t'(adc_in);
  assign last_write = wr_en && (state_q == CAPTURE) && (wr_ptr_q == '1);

  // Capture FSM with write pointer, accumulator and baseline result.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      wr_ptr_q         <= '0;
      sum_q            <= '0;
      baseline_q       <= '0;
      baseline_valid_q <= 1'b0;
    end else if (abort) begin
      state_q          <= IDLE;
      wr_ptr_q         <= '0;
      sum_q            <= '0;
      baseline_valid_q <= 1'b0;
    end else if (arm) begin
      // Restart from any state; the old baseline stays visible but invalid.
      state_q          <= ARMED;
      wr_ptr_q         <= '0;
      sum_q            <= '0;
      baseline_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ARMED: begin
          if (trig) state_q <= CAPTURE;
          if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            sum_q    <= sum_d;
          end
        end
        CAPTURE: begin
          if (wr_en) begin
            // Pointer wraps to 0 naturally on the 512th write.
            wr_ptr_q <= wr_ptr_q + 1'b1;
            sum_q    <= sum_d;
            if (last_write) begin
              state_q          <= DONE;
              baseline_q       <= round_mean(sum_d);
              baseline_valid_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  capture_ram u_capture_ram (
    .clk    (clk),
    .we     (wr_en),
    .wraddr (wr_ptr_q),
    .wdata  (adc_in),
    .rdaddr (rdaddr),
    .rdata  (adc_val)
  );

  assign busy           = (state_q == ARMED) || (state_q == CAPTURE);
  assign done           = (state_q == DONE);
  assign baseline       = baseline_q;
  assign baseline_valid = baseline_valid_q;

endmodule

// File: tb/tb_adc_baseline_capture.sv
// Directed testbench for adc_baseline_capture.
module tb_adc_baseline_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm, abort, trig, adc_valid;
  logic [13:0] adc_in;
  logic [8:0]  rdaddr;
  logic [13:0] adc_val, baseline;
  logic        busy, done, baseline_valid;

  int checks   = 0;
  int failures = 0;

  adc_baseline_capture dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .arm            (arm),
    .abort          (abort),
    .trig           (trig),
    .adc_in         (adc_in),
    .adc_valid      (adc_valid),
    .rdaddr         (rdaddr),
    .adc_val        (adc_val),
    .busy           (busy),
    .done           (done),
    .baseline       (baseline),
    .baseline_valid (baseline_valid)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  // Feed samples start..start+n-1. Sample i is (ramp ? i + value : value).
  // trig accompanies sample 0; in gapped mode every valid cycle is preceded
  // by an invalid one carrying junk, and trig rides the first invalid cycle.
  task automatic feed(input int start, input int n, input bit ramp,
                      input int value, input bit gapped);
    for (int i = start; i < start + n; i++) begin
      if (gapped) begin
        adc_valid = 1'b0;
        adc_in    = 14'h1555;
        trig      = (i == 0);
        tick();
      end
      adc_valid = 1'b1;
      adc_in    = ramp ? 14'(i + value) : 14'(value);
      trig      = (i == 0) && !gapped;
      if (i == 511) begin
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL done_before_last: got %0b expected 0", done); end
      end
      tick();
    end
    adc_valid = 1'b0;
    trig      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; arm = 0; abort = 0; trig = 0; adc_valid = 0; adc_in = '0; rdaddr = '0;
    #12;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b expected 0", done); end
    checks++; if (baseline !== 14'd0) begin failures++; $display("FAIL reset_baseline: got %0d expected 0", baseline); end
    checks++; if (baseline_valid !== 1'b0) begin failures++; $display("FAIL reset_bvalid: got %0b expected 0", baseline_valid); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_constant();
    int addrs[3] = '{0, 255, 511};
    pulse_arm();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL const_armed_busy: got %0b expected 1", busy); end
    feed(0, 512, 1'b0, 4777, 1'b0);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL const_done: got %0b expected 1", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL const_busy: got %0b expected 0", busy); end
    checks++; if (baseline !== 14'd4777) begin failures++; $display("FAIL const_baseline: got %0d expected 4777", baseline); end
    checks++; if (baseline_valid !== 1'b1) begin failures++; $display("FAIL const_bvalid: got %0b expected 1", baseline_valid); end
    foreach (addrs[k]) begin
      rdaddr = 9'(addrs[k]);
      #1;
      checks++; if (adc_val !== 14'd4777) begin failures++; $display("FAIL const_read[%0d]: got %0d expected 4777", addrs[k], adc_val); end
    end
  endtask

  task automatic test_rearm_from_done();
    pulse_arm();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rearm_done: got %0b expected 0", done); end
    checks++; if (baseline_valid !== 1'b0) begin failures++; $display("FAIL rearm_bvalid: got %0b expected 0", baseline_valid); end
    checks++; if (baseline !== 14'd4777) begin failures++; $display("FAIL rearm_baseline_kept: got %0d expected 4777", baseline); end
    feed(0, 300, 1'b0, 4775, 1'b0);
    checks++; if (baseline !== 14'd4777) begin failures++; $display("FAIL rearm_baseline_mid: got %0d expected 4777", baseline); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rearm_busy_mid: got %0b expected 1", busy); end
    feed(300, 212, 1'b0, 4775, 1'b0);
    checks++; if (baseline !== 14'd4775) begin failures++; $display("FAIL rearm_baseline_new: got %0d expected 4775", baseline); end
    checks++; if (baseline_valid !== 1'b1) begin failures++; $display("FAIL rearm_bvalid_new: got %0b expected 1", baseline_valid); end
  endtask

  task automatic test_ramp();
    pulse_arm();
    feed(0, 512, 1'b1, 0, 1'b0);
    checks++; if (baseline !== 14'd256) begin failures++; $display("FAIL ramp_baseline: got %0d expected 256", baseline); end
    rdaddr = 9'd300;
    #1;
    checks++; if (adc_val !== 14'd300) begin failures++; $display("FAIL ramp_read300: got %0d expected 300", adc_val); end
  endtask

  task automatic test_gapped();
    int addrs[4] = '{0, 1, 256, 511};
    pulse_abort();
    // trig and valid data in IDLE must neither start a capture nor write.
    trig = 1'b1; adc_valid = 1'b1; adc_in = 14'd9999;
    repeat (4) tick();
    trig = 1'b0; adc_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_trig_busy: got %0b expected 0", busy); end
    rdaddr = 9'd0;
    #1;
    checks++; if (adc_val !== 14'd0) begin failures++; $display("FAIL idle_no_write: got %0d expected 0", adc_val); end
    pulse_arm();
    feed(0, 512, 1'b1, 1000, 1'b1);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL gap_done: got %0b expected 1", done); end
    checks++; if (baseline !== 14'd1256) begin failures++; $display("FAIL gap_baseline: got %0d expected 1256", baseline); end
    foreach (addrs[k]) begin
      rdaddr = 9'(addrs[k]);
      #1;
      checks++; if (adc_val !== 14'(addrs[k] + 1000)) begin failures++; $display("FAIL gap_read[%0d]: got %0d expected %0d", addrs[k], adc_val, addrs[k] + 1000); end
    end
  endtask

  task automatic test_extremes();
    pulse_arm();
    feed(0, 512, 1'b0, 16383, 1'b0);
    checks++; if (baseline !== 14'd16383) begin failures++; $display("FAIL max_baseline: got %0d expected 16383", baseline); end
    checks++; if (baseline_valid !== 1'b1) begin failures++; $display("FAIL max_bvalid: got %0b expected 1", baseline_valid); end
    // Trigger-cycle write to address 0 while reading it: old word until edge.
    pulse_arm();
    rdaddr = 9'd0; trig = 1'b1; adc_valid = 1'b1; adc_in = 14'd0;
    #1;
    checks++; if (adc_val !== 14'd16383) begin failures++; $display("FAIL rdw_old_word: got %0d expected 16383", adc_val); end
    tick();
    checks++; if (adc_val !== 14'd0) begin failures++; $display("FAIL rdw_new_word: got %0d expected 0", adc_val); end
    feed(1, 511, 1'b0, 0, 1'b0);
    checks++; if (baseline !== 14'd0) begin failures++; $display("FAIL zero_baseline: got %0d expected 0", baseline); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_done: got %0b expected 1", done); end
  endtask

  task automatic test_abort_reset();
    pulse_arm();
    feed(0, 100, 1'b0, 3000, 1'b0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_pre_busy: got %0b expected 1", busy); end
    pulse_abort();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %0b expected 0", busy); end
    checks++; if (baseline_valid !== 1'b0) begin failures++; $display("FAIL abort_bvalid: got %0b expected 0", baseline_valid); end
    rdaddr = 9'd50;
    #1;
    checks++; if (adc_val !== 14'd3000) begin failures++; $display("FAIL abort_retained: got %0d expected 3000", adc_val); end
    pulse_arm();
    feed(0, 512, 1'b0, 4780, 1'b0);
    checks++; if (baseline !== 14'd4780) begin failures++; $display("FAIL abort_recap_baseline: got %0d expected 4780", baseline); end
    // Reset mid-capture must clear outputs without waiting for a clock edge.
    pulse_arm();
    feed(0, 50, 1'b0, 123, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_rst_busy: got %0b expected 0", busy); end
    checks++; if (baseline !== 14'd0) begin failures++; $display("FAIL async_rst_baseline: got %0d expected 0", baseline); end
    checks++; if (done !== 1'b0 || baseline_valid !== 1'b0) begin failures++; $display("FAIL async_rst_flags: got %0b%0b expected 00", done, baseline_valid); end
    rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_rst_idle: got %0b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_rearm_from_done();
    test_ramp();
    test_gapped();
    test_extremes();
    test_abort_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
